huffman_dec: RTL

HUFFMAN_DEC -- requirements
Module: huffman_dec

---
 rtl/huffman_pkg.sv | 9 +
 rtl/huffman_dec_loc.sv | 27 ++
 rtl/huffman_dec.sv | 111 +++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared constants for the prefix-code Huffman encoder/decoder pair.
// Code k: k leading ones, a zero, then one payload bit; seven leading ones is illegal.
package huffman_pkg;
    localparam int W       = 8;
    localparam int C       = 4;
    localparam int MAX_K   = 6;
    localparam int MAX_SYM = 13;
    localparam logic [MAX_K:0] ILLEGAL_PREFIX = '1;
endpackage

// File: rtl/huffman_dec_loc.sv
// Leading-ones counter over the head of the decoder bit buffer.
// Only the first `fill` bits are considered valid, so the count stops at fill.
import huffman_pkg::*;

module huffman_dec_loc #(
    parameter int W = huffman_pkg::W
) (
    input  logic [W-1:0]                head,
    input  logic [$clog2(2*W+1)-1:0]    fill,
    output logic [$clog2(W+1)-1:0]      ones
);
    localparam int KW = $clog2(W+1);

    logic run;

    always_comb begin
        ones = '0;
        run  = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (run && (i < int'(fill)) && head[W-1-i]) begin
                ones = ones + KW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end
endmodule

// File: rtl/huffman_dec.sv
// Streaming Huffman decoder: packs bytes into a 2W-bit MSB-aligned buffer and
// emits at most one (symbol, length) pair per cycle through a stallable output register.
import huffman_pkg::*;

module huffman_dec #(
    parameter int W = huffman_pkg::W,
    parameter int C = huffman_pkg::C
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_in,
    input  logic         en_in,
    output logic         rdy_out,
    output logic [C-1:0] sym_out,
    output logic [C-1:0] w_out,
    output logic         en_out,
    input  logic         stall_in,
    output logic         err_out
);
    localparam int FW = $clog2(2*W+1);
    localparam int KW = $clog2(W+1);

    logic [2*W-1:0] buf_q, buf_d;
    logic [FW-1:0]  fill_q, fill_d;
    logic [C-1:0]   sym_q, sym_d;
    logic [C-1:0]   w_q, w_d;
    logic           en_q, en_d;
    logic           err_q, err_d;

    logic [KW-1:0]  ones;
    logic [FW-1:0]  code_len;
    logic [FW-1:0]  shift_amt;
    logic [FW-1:0]  fill_mid;
    logic [2*W-1:0] after_shift;
    logic [2*W-1:0] head_rest;
    logic           bit_b;
    logic           complete;
    logic           illegal;
    logic           load;
    logic           accept;

    huffman_dec_loc #(.W(W)) u_loc (
        .head (buf_q[2*W-1 -: W]),
        .fill (fill_q),
        .ones (ones)
    );

    assign rdy_out = (fill_q <= FW'(W));

    // Shift out the consumed head first, then append the new byte right behind what remains.
    always_comb begin
        code_len  = FW'(ones) + FW'(2);
        head_rest = buf_q << (ones + KW'(1));
        bit_b     = head_rest[2*W-1];
        complete  = (ones <= KW'(MAX_K)) && (fill_q >= code_len);
        illegal   = (fill_q >= FW'(W)) && (buf_q[2*W-1 -: MAX_K+1] == ILLEGAL_PREFIX);
        load      = !en_q || !stall_in;
        accept    = en_in && rdy_out;

        sym_d     = sym_q;
        w_d       = w_q;
        en_d      = en_q;
        err_d     = 1'b0;
        shift_amt = '0;

        if (load) begin
            en_d = 1'b0;
            if (complete) begin
                sym_d     = {ones[C-2:0], bit_b};
                w_d       = C'(code_len);
                en_d      = 1'b1;
                shift_amt = code_len;
            end else if (illegal) begin
                err_d     = 1'b1;
                shift_amt = FW'(W);
            end
        end

        after_shift = buf_q << shift_amt;
        fill_mid    = fill_q - shift_amt;
        buf_d       = after_shift;
        fill_d      = fill_mid;
        if (accept) begin
            buf_d  = after_shift | ({d_in, {W{1'b0}}} >> fill_mid);
            fill_d = fill_mid + FW'(W);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q  <= '0;
            fill_q <= '0;
            sym_q  <= '0;
            w_q    <= '0;
            en_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
            sym_q  <= sym_d;
            w_q    <= w_d;
            en_q   <= en_d;
            err_q  <= err_d;
        end
    end

    assign sym_out = sym_q;
    assign w_out   = w_q;
    assign en_out  = en_q;
    assign err_out = err_q;
endmodule
